// File: rtl/interp_pkg.sv
// Shared constants and types for the interpolator timing-control blocks.
// Float format: 1 sign, 8 exponent (bias 127), 10 mantissa.
package interp_pkg;

   localparam int SIGN_BIT  = 18;
   localparam int EXP_MSB   = 17;
   localparam int EXP_LSB   = 10;
   localparam int MAN_W     = 10;
   localparam int EXP_BIAS  = 127;
   localparam int FLT_W     = SIGN_BIT + 1;
   localparam int PRIME_CNT = 4;

   typedef enum logic [1:0] {
      FILL,
      RUN,
      STALL
   } nco_state_e;

endpackage

// File: rtl/interp_nco_frac2flt.sv
// Combinational conversion of an unsigned PHASE_W-bit fraction (value f/2^PHASE_W)
// into the 19-bit float; mantissa is truncated, zero maps to all-zero.
module frac2flt
   import interp_pkg::*;
#(
   parameter int PHASE_W = 24
) (
   input  logic [PHASE_W-1:0] frac_i,
   output logic [FLT_W-1:0]   flt_o
);

   logic [4:0]               lz;
   logic [PHASE_W-1:0]       norm;
   logic [EXP_MSB-EXP_LSB:0] expo;
   logic [MAN_W-1:0]         man;

   // Lowest-to-highest scan so the most significant set bit wins.
   always_comb begin
      lz = 5'(PHASE_W - 1);
      for (int i = 0; i < PHASE_W; i++) begin
         if (frac_i[i]) begin
            lz = 5'(PHASE_W - 1 - i);
         end
      end
   end

   assign norm  = frac_i << lz;
   assign man   = MAN_W'(norm >> (PHASE_W - 1 - MAN_W));
   assign expo  = 8'(EXP_BIAS - 1) - {3'b000, lz};
   assign flt_o = (frac_i == '0) ? '0 : {1'b0, expo, man};

endmodule

// File: rtl/interp_nco.sv
// Phase-accumulator timing control for the Farrow interpolator: pulls one sample
// per accumulator wrap and presents the fractional interval mu as a float.
module interp_nco
   import interp_pkg::*;
#(
   parameter int PHASE_W    = 24,
   parameter int DATA_WIDTH = 19
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [PHASE_W:0]      step,
   input  logic                  step_load,
   input  logic [DATA_WIDTH-1:0] sample_in,
   input  logic                  sample_valid,
   output logic                  sample_ready,
   output logic [DATA_WIDTH-1:0] x_out,
   output logic                  load,
   output logic [DATA_WIDTH-1:0] mu_out,
   output logic                  out_valid
);

   localparam logic [PHASE_W:0] STEP_ONE = {1'b1, {PHASE_W{1'b0}}};

   nco_state_e            state_q, state_d;
   logic [PHASE_W-1:0]    acc_q, acc_d;
   logic [PHASE_W:0]      step_q, step_d;
   logic [2:0]            fill_q, fill_d;
   logic [DATA_WIDTH-1:0] x_q, x_d;
   logic [DATA_WIDTH-1:0] mu_q, mu_d;
   logic                  load_q, load_d;
   logic                  valid_q, valid_d;

   logic [PHASE_W:0]      sum;
   logic                  carry;
   logic [FLT_W-1:0]      muNext;

   assign sum   = {1'b0, acc_q} + step_q;
   assign carry = sum[PHASE_W];

   frac2flt #(
      .PHASE_W (PHASE_W)
   ) u_frac2flt (
      .frac_i (sum[PHASE_W-1:0]),
      .flt_o  (muNext)
   );

   // Steps above 1.0 are clamped so at most one sample is consumed per output.
   assign step_d = step_load ? ((step > STEP_ONE) ? STEP_ONE : step) : step_q;

   always_comb begin
      state_d      = state_q;
      acc_d        = acc_q;
      fill_d       = fill_q;
      x_d          = x_q;
      mu_d         = mu_q;
      load_d       = 1'b0;
      valid_d      = 1'b0;
      sample_ready = 1'b0;

      unique case (state_q)
         FILL: begin
            sample_ready = 1'b1;
            if (sample_valid) begin
               x_d    = sample_in;
               load_d = 1'b1;
               fill_d = fill_q + 3'd1;
               if (fill_q == 3'(PRIME_CNT - 1)) begin
                  fill_d  = '0;
                  acc_d   = '0;
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            sample_ready = carry;
            if (!carry || sample_valid) begin
               acc_d   = sum[PHASE_W-1:0];
               valid_d = 1'b1;
               mu_d    = muNext;
               if (carry) begin
                  load_d = 1'b1;
                  x_d    = sample_in;
               end
            end else begin
               state_d = STALL;
            end
         end
         STALL: begin
            sample_ready = 1'b1;
            if (sample_valid) begin
               acc_d   = sum[PHASE_W-1:0];
               valid_d = 1'b1;
               mu_d    = muNext;
               load_d  = 1'b1;
               x_d     = sample_in;
               state_d = RUN;
            end
         end
         default: begin
            state_d = FILL;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= FILL;
         acc_q   <= '0;
         step_q  <= STEP_ONE;
         fill_q  <= '0;
         x_q     <= '0;
         mu_q    <= '0;
         load_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         step_q  <= step_d;
         fill_q  <= fill_d;
         x_q     <= x_d;
         mu_q    <= mu_d;
         load_q  <= load_d;
         valid_q <= valid_d;
      end
   end

   assign x_out     = x_q;
   assign mu_out    = mu_q;
   assign load      = load_q;
   assign out_valid = valid_q;

endmodule

// File: tb/tb_interp_nco.sv
// Scoreboard bench for interp_nco: directed stimulus pushes hand-computed
// per-cycle expectations, a monitor pops and compares after each clock edge.
module tb_interp_nco;

   localparam int PHASE_W = 24;

   localparam logic [18:0] ONE = 19'h1FC00;
   localparam logic [18:0] Q1  = 19'h1F400;
   localparam logic [18:0] Q2  = 19'h1F800;
   localparam logic [18:0] Q3  = 19'h1FA00;

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic [PHASE_W:0]  step = '0;
   logic              step_load = 1'b0;
   logic [18:0]       sample_in = '0;
   logic              sample_valid = 1'b0;
   logic              sample_ready;
   logic [18:0]       x_out;
   logic              load;
   logic [18:0]       mu_out;
   logic              out_valid;

   typedef struct packed {
      logic        v;
      logic        l;
      logic [18:0] mu;
      logic [18:0] x;
   } exp_t;

   exp_t expQ[$];
   int   nVectors = 0;
   int   nMiscompares = 0;

   interp_nco #(
      .PHASE_W    (PHASE_W),
      .DATA_WIDTH (19)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .step         (step),
      .step_load    (step_load),
      .sample_in    (sample_in),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .x_out        (x_out),
      .load         (load),
      .mu_out       (mu_out),
      .out_valid    (out_valid)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      nVectors++;
      if (act !== req) begin
         nMiscompares++;
         $display("[TB] FAIL %s: got 0x%05h, expected 0x%05h", name, act, req);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [18:0] s, input logic sl,
                                input logic [PHASE_W:0] st, input logic eV, input logic eL,
                                input logic [18:0] eMu, input logic [18:0] eX);
      @(negedge clk);
      sample_valid = v;
      sample_in    = s;
      step_load    = sl;
      step         = st;
      expQ.push_back({eV, eL, eMu, eX});
   endtask

   // Monitor: one expectation per clock while the queue holds entries.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("out_valid", 32'(out_valid), 32'(e.v));
            checkOutput("load",      32'(load),      32'(e.l));
            checkOutput("mu_out",    32'(mu_out),    32'(e.mu));
            checkOutput("x_out",     32'(x_out),     32'(e.x));
         end
      end
   end

   initial begin
      $display("[TB] start");
      #2 rst_n = 1'b0;
      #10;
      checkOutput("rst_x_out",     32'(x_out),     32'h0);
      checkOutput("rst_load",      32'(load),      32'h0);
      checkOutput("rst_mu_out",    32'(mu_out),    32'h0);
      checkOutput("rst_out_valid", 32'(out_valid), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Priming: four handshakes, an idle cycle in between, step 0.25 loaded on the last.
      applyStimulus(1'b0, 19'h0,   1'b0, '0,           1'b0, 1'b0, 19'h0, 19'h0);
      applyStimulus(1'b1, ONE,     1'b0, '0,           1'b0, 1'b1, 19'h0, ONE);
      applyStimulus(1'b1, ONE,     1'b0, '0,           1'b0, 1'b1, 19'h0, ONE);
      applyStimulus(1'b1, ONE,     1'b0, '0,           1'b0, 1'b1, 19'h0, ONE);
      applyStimulus(1'b0, 19'h0,   1'b0, '0,           1'b0, 1'b0, 19'h0, ONE);
      applyStimulus(1'b1, ONE,     1'b1, 25'h0400000,  1'b0, 1'b1, 19'h0, ONE);

      // Step 0.25 with samples always valid.
      applyStimulus(1'b1, 19'h01,  1'b0, '0, 1'b1, 1'b0, Q1,    ONE);
      applyStimulus(1'b1, 19'h02,  1'b0, '0, 1'b1, 1'b0, Q2,    ONE);
      applyStimulus(1'b1, 19'h03,  1'b0, '0, 1'b1, 1'b0, Q3,    ONE);
      applyStimulus(1'b1, 19'h04,  1'b0, '0, 1'b1, 1'b1, 19'h0, 19'h04);
      applyStimulus(1'b1, 19'h05,  1'b0, '0, 1'b1, 1'b0, Q1,    19'h04);
      applyStimulus(1'b1, 19'h06,  1'b0, '0, 1'b1, 1'b0, Q2,    19'h04);
      applyStimulus(1'b1, 19'h07,  1'b0, '0, 1'b1, 1'b0, Q3,    19'h04);
      applyStimulus(1'b1, 19'h08,  1'b0, '0, 1'b1, 1'b1, 19'h0, 19'h08);
      applyStimulus(1'b1, 19'h09,  1'b0, '0, 1'b1, 1'b0, Q1,    19'h08);
      applyStimulus(1'b1, 19'h0A,  1'b0, '0, 1'b1, 1'b0, Q2,    19'h08);
      applyStimulus(1'b1, 19'h0B,  1'b0, '0, 1'b1, 1'b0, Q3,    19'h08);

      // Valid dropped at the wrap for three cycles: stall with mu frozen.
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 19'h0, 1'b0, '0, 1'b0, 1'b0, Q3, 19'h08);
      end
      applyStimulus(1'b1, 19'h0ABCD, 1'b0, '0, 1'b1, 1'b1, 19'h0, 19'h0ABCD);
      applyStimulus(1'b1, 19'h0E,    1'b0, '0, 1'b1, 1'b0, Q1,    19'h0ABCD);
      applyStimulus(1'b1, 19'h0F,    1'b0, '0, 1'b1, 1'b0, Q2,    19'h0ABCD);
      applyStimulus(1'b1, 19'h10,    1'b0, '0, 1'b1, 1'b0, Q3,    19'h0ABCD);

      // Step change on a wrap cycle still uses the old step; then step = 1 LSB.
      applyStimulus(1'b1, 19'h11, 1'b1, 25'h0000001, 1'b1, 1'b1, 19'h0,     19'h11);
      applyStimulus(1'b1, 19'h12, 1'b0, '0,          1'b1, 1'b0, 19'h19C00, 19'h11);
      applyStimulus(1'b1, 19'h13, 1'b0, '0,          1'b1, 1'b0, 19'h1A000, 19'h11);

      // Oversized step clamps to 1.0: load every cycle, mu fixed at acc=3.
      applyStimulus(1'b1, 19'h14, 1'b1, 25'h1FFFFFF, 1'b1, 1'b0, 19'h1A200, 19'h11);
      applyStimulus(1'b1, 19'h15, 1'b0, '0,          1'b1, 1'b1, 19'h1A200, 19'h15);
      applyStimulus(1'b1, 19'h16, 1'b0, '0,          1'b1, 1'b1, 19'h1A200, 19'h16);

      // Step 0 freezes mu and stops loads.
      applyStimulus(1'b1, 19'h17, 1'b1, 25'h0000000, 1'b1, 1'b1, 19'h1A200, 19'h17);
      applyStimulus(1'b1, 19'h18, 1'b0, '0,          1'b1, 1'b0, 19'h1A200, 19'h17);
      applyStimulus(1'b1, 19'h19, 1'b1, 25'h1000000, 1'b1, 1'b0, 19'h1A200, 19'h17);
      applyStimulus(1'b1, 19'h1A, 1'b0, '0,          1'b1, 1'b1, 19'h1A200, 19'h1A);

      // Asynchronous reset mid-run while load is high.
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      checkOutput("arst_x_out",     32'(x_out),     32'h0);
      checkOutput("arst_load",      32'(load),      32'h0);
      checkOutput("arst_mu_out",    32'(mu_out),    32'h0);
      checkOutput("arst_out_valid", 32'(out_valid), 32'h0);
      @(negedge clk);
      sample_valid = 1'b0;
      step_load    = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      // Re-prime after reset; step back at its reset value of 1.0.
      applyStimulus(1'b1, 19'h30, 1'b0, '0, 1'b0, 1'b1, 19'h0, 19'h30);
      applyStimulus(1'b1, 19'h31, 1'b0, '0, 1'b0, 1'b1, 19'h0, 19'h31);
      applyStimulus(1'b1, 19'h32, 1'b0, '0, 1'b0, 1'b1, 19'h0, 19'h32);
      applyStimulus(1'b0, 19'h0,  1'b0, '0, 1'b0, 1'b0, 19'h0, 19'h32);
      applyStimulus(1'b1, 19'h33, 1'b0, '0, 1'b0, 1'b1, 19'h0, 19'h33);
      applyStimulus(1'b1, 19'h34, 1'b0, '0, 1'b1, 1'b1, 19'h0, 19'h34);
      applyStimulus(1'b1, 19'h35, 1'b0, '0, 1'b1, 1'b1, 19'h0, 19'h35);
      applyStimulus(1'b0, 19'h0,  1'b0, '0, 1'b0, 1'b0, 19'h0, 19'h35);

      @(negedge clk);
      @(negedge clk);
      checkOutput("queue_drained", 32'(expQ.size()), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
      $finish;
   end

endmodule

// File: doc/interp_nco.md
# interp_nco

Timing-control stage directly upstream of the Farrow cubic interpolator. A phase accumulator advances by a programmable step every clock. On each accumulator wrap, the block pulls one new input sample through a valid/ready handshake and pulses `load`. Every cycle it also converts the fractional phase into the 19-bit float `mu` (1 sign, 8 exponent bias 127, 10 mantissa) consumed by the interpolator.

## Interface
- `PHASE_W`, 24: accumulator fraction width; the fractional interval is `acc/2^PHASE_W`; legal range 11..24.
- `DATA_WIDTH`, 19: sample/float width; fixed format, not to be changed.
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- step  in  PHASE_W+1  unsigned step; 2^PHASE_W = 1.0 input sample per output.
- step_load  in  1  latch `step` into `step_r`.
- sample_in  in  19  upstream sample (float).
- sample_valid  in  1  upstream has a sample.
- sample_ready  out  1  block accepts `sample_in` this cycle (combinational from state/acc/step_r).
- x_out  out  19  accepted sample, registered; reset 0.
- load  out  1  one-cycle pulse: interpolator shifts `x_out` in; reset 0.
- mu_out  out  19  float fractional interval; reset 0.
- out_valid  out  1  `mu_out` is a valid output instant; reset 0.

## Operation
- Registers: `acc[PHASE_W-1:0]`, `step_r[PHASE_W:0]`, `state`, `fill_cnt[2:0]`. Reset: acc=0, step_r=2^PHASE_W, fill_cnt=0, state=FILL, all outputs 0.
- `step_load`: `step_r <= min(step, 2^PHASE_W)` in any state; takes effect from the next cycle. A step of 0 is legal; mu then freezes and no samples are loaded.
- Combinational `sum = acc + step_r` (PHASE_W+1 bits); `carry = sum[PHASE_W]`.
- FILL:
  - sample_ready=1, out_valid=0.
  - Each handshake (valid&&ready): x_out<=sample_in, load<=1, fill_cnt++.
  - On the 4th handshake: acc<=0, go RUN.
- RUN:
  - sample_ready=carry.
  - No carry: acc<=sum, load<=0, out_valid<=1, mu_out<=f2f(sum[PHASE_W-1:0]).
  - Carry with sample_valid: same as no carry, but also load<=1 and x_out<=sample_in.
  - Carry without sample_valid: acc held, load<=0, out_valid<=0, go STALL.
- STALL:
  - sample_ready=1, out_valid=0, load=0.
  - On sample_valid: perform the RUN carry update using the current step_r, then go RUN.
- f2f (fraction to float):
  - f==0 gives 19'h00000.
  - Otherwise lz = leading zeros of f; exponent = 126-lz; mantissa = the 10 bits below the leading one, truncated and zero-padded; sign 0.
- Minimum exponent is 126-(PHASE_W-1) ≥ 103, so there is no underflow.

## Timing
- All outputs are registered; mu_out/load/x_out for one instant are updated in the same cycle, one clock after the decision cycle.
- At most one sample is accepted per cycle; a sample is never accepted while `sample_ready`=0.
- A wrap to exactly 0 counts as a carry, e.g. step=1.0 loads every cycle with mu=0.
- A step_load arriving in the same cycle as a carry still uses the old step_r for that update.
- Reset asserted mid-operation clears everything immediately; FILL restarts and the 4 priming samples are required again.
- Steady-state throughput is one out_valid per clock, except during FILL/STALL.

## Structure
- Package `interp_pkg` holds:
  - FP field constants (SIGN_BIT=18, EXP_MSB=17, EXP_LSB=10, MAN_W=10, EXP_BIAS=127).
  - The state enum {FILL, RUN, STALL}.
  - PRIME_CNT=4.
- Sub-module `frac2flt`: purely combinational PHASE_W-bit fraction to 19-bit float converter (leading-zero count + normalize shift). It is reusable by other timing blocks.

## Test plan
- Reset, then 4 samples 0x1FC00 with valid held high: 4 load pulses, out_valid=0 throughout, state RUN on the 5th cycle with acc=0.
- step=0x400000 (0.25), samples always valid: mu_out cycles 0x1F400, 0x1F800, 0x1FA00, 0x00000. The load pulse coincides with 0x00000 every 4th output.
- Same setup, sample_valid dropped at a wrap for 3 cycles: out_valid=0 for 3 cycles, mu_out/acc frozen, then resumes with load=1 and mu_out=0x00000.
- step=1, run 1 cycle after FILL: mu_out=0x19C00 (2^-24), no load.
- step=0x1FFFFFF (above 1.0): clamped to 0x1000000; load=1 and mu_out=0 every cycle.
- Reset asserted mid-RUN with load high: all outputs 0 asynchronously; the next 4 samples re-prime.
